// File: rtl/prog_loader_if.sv
// Byte-stream loader and instruction-memory write port shared by prog_loader and its host.
interface prog_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        inst_wr_en;
    logic [4:0]  inst_wr_addr;
    logic [19:0] inst_wr_data;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output inst_wr_en,
        output inst_wr_addr,
        output inst_wr_data
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  inst_wr_en,
        input  inst_wr_addr,
        input  inst_wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Loads a count-prefixed 3-byte-per-word program into instruction memory, then runs the CPU.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned MAX_INST = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    prog_loader_if.slave     bus,
    input  logic             clear,
    input  logic             cpu_halted,
    output logic             cpu_run,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [3:0] {
        StIdle,
        StB0,
        StB1,
        StB2,
        StWrite,
        StRun,
        StDone,
        StError
`ifdef PROG_LOADER_CHECKSUM_EN
        , StCheck
`endif
    } state_e;

    state_e           r_state, w_state;
    // Six bits so the address can reach 32 after the last write without wrapping to 0.
    logic [5:0]       r_addr, w_addr;
    logic [5:0]       r_count, w_count;
    logic [19:0]      r_word, w_word;
    logic [CNT_W-1:0] r_run_cycles, w_run_cycles;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]       r_xor, w_xor;
`endif

    always_comb begin
        w_in_ready = (r_state == StIdle) || (r_state == StB0) ||
                     (r_state == StB1)   || (r_state == StB2);
`ifdef PROG_LOADER_CHECKSUM_EN
        w_in_ready = w_in_ready || (r_state == StCheck);
`endif
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_addr == (r_count - 6'd1));

    always_comb begin
        w_state      = r_state;
        w_addr       = r_addr;
        w_count      = r_count;
        w_word       = r_word;
        w_run_cycles = r_run_cycles;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_xor        = r_xor;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (bus.in_data == 8'd0 || 32'(bus.in_data) > MAX_INST) begin
                        w_state = StError;
                    end else begin
                        w_count = bus.in_data[5:0];
                        w_addr  = 6'd0;
                        w_state = StB0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        w_xor   = 8'd0;
`endif
                    end
                end
            end
            StB0: begin
                if (w_accept) begin
                    w_word[19:16] = bus.in_data[3:0];
                    w_state       = StB1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_xor         = r_xor ^ bus.in_data;
`endif
                end
            end
            StB1: begin
                if (w_accept) begin
                    w_word[15:8] = bus.in_data;
                    w_state      = StB2;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_xor        = r_xor ^ bus.in_data;
`endif
                end
            end
            StB2: begin
                if (w_accept) begin
                    w_word[7:0] = bus.in_data;
                    w_state     = StWrite;
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_xor       = r_xor ^ bus.in_data;
`endif
                end
            end
            StWrite: begin
                w_addr = r_addr + 6'd1;
                if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    w_state      = StCheck;
`else
                    w_state      = StRun;
                    w_run_cycles = '0;
`endif
                end else begin
                    w_state = StB0;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StCheck: begin
                if (w_accept) begin
                    if (bus.in_data == r_xor) begin
                        w_state      = StRun;
                        w_run_cycles = '0;
                    end else begin
                        w_state = StError;
                    end
                end
            end
`endif
            StRun: begin
                // Halt freezes the counter in the same cycle it is sampled.
                if (cpu_halted) begin
                    w_state = StDone;
                end else if (r_run_cycles != {CNT_W{1'b1}}) begin
                    w_run_cycles = r_run_cycles + 1'b1;
                end
            end
            StDone, StError: begin
                if (clear) begin
                    w_state = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_addr       <= 6'd0;
            r_count      <= 6'd0;
            r_word       <= 20'd0;
            r_run_cycles <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
`endif
        end else begin
            r_state      <= w_state;
            r_addr       <= w_addr;
            r_count      <= w_count;
            r_word       <= w_word;
            r_run_cycles <= w_run_cycles;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_xor        <= w_xor;
`endif
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.inst_wr_en   = (r_state == StWrite);
    assign bus.inst_wr_addr = r_addr[4:0];
    assign bus.inst_wr_data = r_word;
    assign cpu_run          = (r_state == StRun) || (r_state == StDone);
    assign done             = (r_state == StDone);
    assign error            = (r_state == StError);
    assign run_cycles       = r_run_cycles;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: load, count errors, run/halt, stalls, reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        cpu_halted = 1'b0;
    logic        cpu_run;
    logic        done;
    logic        error;
    logic [15:0] run_cycles;

    prog_loader_if bus ();

    prog_loader #(
        .MAX_INST (32),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clear      (clear),
        .cpu_halted (cpu_halted),
        .cpu_run    (cpu_run),
        .done       (done),
        .error      (error),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_wr = 0;
    int long_strobe = 0;
    logic        prev_wr = 1'b0;
    logic [4:0]  log_addr [64];
    logic [19:0] log_data [64];

    // {in_ready, wr_en, wr_addr, wr_data, cpu_run, done, error, run_cycles}
    logic [45:0] obs;
    assign obs = {bus.in_ready, bus.inst_wr_en, bus.inst_wr_addr, bus.inst_wr_data,
                  cpu_run, done, error, run_cycles};
    localparam logic [45:0] IdleVec = {1'b1, 1'b0, 5'd0, 20'd0, 3'b000, 16'd0};

    always @(posedge clk) begin
        if (bus.inst_wr_en && n_wr < 64) begin
            log_addr[n_wr] <= bus.inst_wr_addr;
            log_data[n_wr] <= bus.inst_wr_data;
        end
        if (bus.inst_wr_en) n_wr <= n_wr + 1;
        if (bus.inst_wr_en && prev_wr) long_strobe <= long_strobe + 1;
        prev_wr <= bus.inst_wr_en;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        clear = 1'b0;
        cpu_halted = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        bus.in_data = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 20) begin
            step();
            k++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout in_ready=0 after %0d cycles, required 1", k);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    // Enter RUN after the final write; the checksum build needs the XOR byte first.
    task automatic finish_load(input logic [7:0] cks);
        step();
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(cks);
`else
        if (cks == 8'hxx) $display("unused");
`endif
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        total++;
        if (obs !== IdleVec) begin
            bad++;
            $display("FAIL reset_during obs=%h required=%h", obs, IdleVec);
        end
        rst = 1'b1;
        step();
        total++;
        if (obs !== IdleVec) begin
            bad++;
            $display("FAIL reset_after obs=%h required=%h", obs, IdleVec);
        end
    endtask

    task automatic test_load();
        int base;
        do_reset();
        base = n_wr;
        send_byte(8'h02);
        send_byte(8'h0A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        total++;
        if (obs !== {1'b0, 1'b1, 5'd0, 20'hABCDE, 3'b000, 16'd0}) begin
            bad++;
            $display("FAIL load_write0 obs=%h required=%h", obs,
                     {1'b0, 1'b1, 5'd0, 20'hABCDE, 3'b000, 16'd0});
        end
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        total++;
        if (obs !== {1'b0, 1'b1, 5'd1, 20'h31234, 3'b000, 16'd0}) begin
            bad++;
            $display("FAIL load_write1 obs=%h required=%h", obs,
                     {1'b0, 1'b1, 5'd1, 20'h31234, 3'b000, 16'd0});
        end
        finish_load(8'h4D);
        total++;
        if (bus.in_ready !== 1'b0 || bus.inst_wr_en !== 1'b0 || cpu_run !== 1'b1 ||
            done !== 1'b0 || error !== 1'b0 || run_cycles !== 16'd0) begin
            bad++;
            $display("FAIL load_run rdy=%b wr=%b run=%b done=%b err=%b cyc=%0d required 0 0 1 0 0 0",
                     bus.in_ready, bus.inst_wr_en, cpu_run, done, error, run_cycles);
        end
        total++;
        if (n_wr - base !== 2 || long_strobe !== 0 || log_addr[base] !== 5'd0 ||
            log_data[base] !== 20'hABCDE || log_addr[base+1] !== 5'd1 ||
            log_data[base+1] !== 20'h31234) begin
            bad++;
            $display("FAIL load_log writes=%0d long=%0d a0=%h d0=%h a1=%h d1=%h required 2 0 0 abcde 1 31234",
                     n_wr - base, long_strobe, log_addr[base], log_data[base],
                     log_addr[base+1], log_data[base+1]);
        end
    endtask

    task automatic test_bad_count();
        logic [7:0] counts [2];
        int base;
        counts[0] = 8'h00;
        counts[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            base = n_wr;
            send_byte(counts[i]);
            total++;
            if ({error, bus.in_ready, bus.inst_wr_en, cpu_run, done} !== 5'b10000) begin
                bad++;
                $display("FAIL bad_count_%h err/rdy/wr/run/done=%b required 10000",
                         counts[i], {error, bus.in_ready, bus.inst_wr_en, cpu_run, done});
            end
            bus.in_data = 8'h01;
            bus.in_valid = 1'b1;
            step();
            step();
            bus.in_valid = 1'b0;
            total++;
            if (error !== 1'b1 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bad_count_hold_%h err=%b rdy=%b required 1 0",
                         counts[i], error, bus.in_ready);
            end
            clear = 1'b1;
            step();
            clear = 1'b0;
            total++;
            if (error !== 1'b0 || bus.in_ready !== 1'b1 || n_wr !== base) begin
                bad++;
                $display("FAIL bad_count_clear_%h err=%b rdy=%b writes=%0d required 0 1 0",
                         counts[i], error, bus.in_ready, n_wr - base);
            end
        end
    endtask

    task automatic test_run();
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h23);
        send_byte(8'h45);
        finish_load(8'h67);
        for (int i = 0; i < 10; i++) begin
            clear = (i == 3);
            step();
        end
        clear = 1'b0;
        total++;
        if ({cpu_run, done, error} !== 3'b100 || run_cycles !== 16'd10) begin
            bad++;
            $display("FAIL run_count run/done/err=%b cyc=%0d required 100 10",
                     {cpu_run, done, error}, run_cycles);
        end
        cpu_halted = 1'b1;
        step();
        total++;
        if ({cpu_run, done, error} !== 3'b110 || run_cycles !== 16'd10) begin
            bad++;
            $display("FAIL run_halt run/done/err=%b cyc=%0d required 110 10",
                     {cpu_run, done, error}, run_cycles);
        end
        cpu_halted = 1'b0;
        bus.in_data = 8'h55;
        bus.in_valid = 1'b1;
        step();
        step();
        step();
        bus.in_valid = 1'b0;
        total++;
        if ({cpu_run, done, bus.in_ready} !== 3'b110 || run_cycles !== 16'd10) begin
            bad++;
            $display("FAIL run_frozen run/done/rdy=%b cyc=%0d required 110 10",
                     {cpu_run, done, bus.in_ready}, run_cycles);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if ({bus.in_ready, cpu_run, done, error} !== 4'b1000) begin
            bad++;
            $display("FAIL run_clear rdy/run/done/err=%b required 1000",
                     {bus.in_ready, cpu_run, done, error});
        end
    endtask

    task automatic test_stall();
        int base;
        do_reset();
        base = n_wr;
        send_byte(8'h01);
        send_byte(8'h0A);
        send_byte(8'hBC);
        for (int i = 0; i < 5; i++) step();
        total++;
        if (bus.in_ready !== 1'b1 || bus.inst_wr_en !== 1'b0 || n_wr !== base) begin
            bad++;
            $display("FAIL stall_hold rdy=%b wr=%b writes=%0d required 1 0 0",
                     bus.in_ready, bus.inst_wr_en, n_wr - base);
        end
        send_byte(8'hDE);
        total++;
        if (bus.inst_wr_en !== 1'b1 || bus.inst_wr_addr !== 5'd0 ||
            bus.inst_wr_data !== 20'hABCDE) begin
            bad++;
            $display("FAIL stall_write wr=%b addr=%h data=%h required 1 0 abcde",
                     bus.inst_wr_en, bus.inst_wr_addr, bus.inst_wr_data);
        end
        finish_load(8'h68);
        total++;
        if (cpu_run !== 1'b1 || n_wr - base !== 1) begin
            bad++;
            $display("FAIL stall_run run=%b writes=%0d required 1 1", cpu_run, n_wr - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = n_wr;
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        rst = 1'b0;
        step();
        total++;
        if (obs !== IdleVec) begin
            bad++;
            $display("FAIL reset_mid obs=%h required=%h", obs, IdleVec);
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step();
        total++;
        if (obs !== IdleVec || n_wr - base !== 1) begin
            bad++;
            $display("FAIL reset_mid_after obs=%h writes=%0d required %h 1",
                     obs, n_wr - base, IdleVec);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] cks [2];
        cks[0] = 8'h0F;
        cks[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            send_byte(8'h01);
            send_byte(8'h0F);
            send_byte(8'hFF);
            send_byte(8'hFF);
            step();
            send_byte(cks[i]);
            total++;
            if ({cpu_run, error} !== ((i == 0) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL checksum_%h run/err=%b required %b", cks[i], {cpu_run, error},
                         (i == 0) ? 2'b10 : 2'b01);
            end
        end
    endtask
`endif

    initial begin
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        test_reset();
        test_load();
        test_bad_count();
        test_run();
        test_stall();
        test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded, required finish");
        $fatal(1, "timeout");
    end

endmodule
